// File: rtl/inc_reg.sv
// Three independent registered event counters (instructions, memory accesses, corrections).
// Define INC_REG_SATURATE_EN to make the counters hold at all-ones instead of wrapping.
module inc_reg #(
    parameter int unsigned CNT_WIDTH = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 instruction_complete,
    input  logic                 mem_access,
    input  logic                 mem_correction,
    output logic [CNT_WIDTH-1:0] instruction_count,
    output logic [CNT_WIDTH-1:0] memory_access_count,
    output logic [CNT_WIDTH-1:0] memory_correction_count
);

    typedef logic [CNT_WIDTH-1:0] cnt_t;

    localparam cnt_t CntMax = '1;

    cnt_t inst_q, inst_d;
    cnt_t acc_q, acc_d;
    cnt_t cor_q, cor_d;

    function automatic cnt_t bump(input cnt_t cur, input logic ev);
        cnt_t nxt;
        nxt = cur;
        if (ev) begin
`ifdef INC_REG_SATURATE_EN
            if (cur != CntMax) begin
                nxt = cur + cnt_t'(1);
            end
`else
            nxt = cur + cnt_t'(1);
`endif
        end
        return nxt;
    endfunction

    always_comb begin
        inst_d = bump(inst_q, instruction_complete);
        acc_d  = bump(acc_q, mem_access);
        cor_d  = bump(cor_q, mem_correction);
    end

    // Reset wins over any event seen on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            inst_q <= '0;
            acc_q  <= '0;
            cor_q  <= '0;
        end else begin
            inst_q <= inst_d;
            acc_q  <= acc_d;
            cor_q  <= cor_d;
        end
    end

    assign instruction_count       = inst_q;
    assign memory_access_count     = acc_q;
    assign memory_correction_count = cor_q;

endmodule

// File: tb/tb_inc_reg.sv
// Scoreboard bench for inc_reg; a narrow counter keeps the wrap/saturate run short.
module tb_inc_reg;

    localparam int unsigned W = 10;

    typedef logic [W-1:0] cnt_t;
    typedef struct packed {
        cnt_t i;
        cnt_t a;
        cnt_t c;
    } exp_t;

    logic clk;
    logic reset;
    logic instruction_complete;
    logic mem_access;
    logic mem_correction;
    cnt_t instruction_count;
    cnt_t memory_access_count;
    cnt_t memory_correction_count;

    int n_tests;
    int n_fail;
    exp_t sb_q[$];
    exp_t model;
    cnt_t all_ones;

    inc_reg #(.CNT_WIDTH(W)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .instruction_complete    (instruction_complete),
        .mem_access              (mem_access),
        .mem_correction          (mem_correction),
        .instruction_count       (instruction_count),
        .memory_access_count     (memory_access_count),
        .memory_correction_count (memory_correction_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic cnt_t model_inc(input cnt_t cur, input logic ev);
        if (!ev) return cur;
`ifdef INC_REG_SATURATE_EN
        if (cur == all_ones) return cur;
`endif
        return cur + cnt_t'(1);
    endfunction

    task automatic pop_and_compare(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_inst"}, 32'(instruction_count), 32'(e.i));
            check({tag, "_acc"}, 32'(memory_access_count), 32'(e.a));
            check({tag, "_cor"}, 32'(memory_correction_count), 32'(e.c));
        end
    endtask

    // Drive one cycle of inputs, predict the result, then compare after the edge.
    task automatic step(input string tag, input logic rst, input logic ii, input logic aa,
                        input logic cc);
        reset                = rst;
        instruction_complete = ii;
        mem_access           = aa;
        mem_correction       = cc;
        if (rst) begin
            model = '0;
        end else begin
            model.i = model_inc(model.i, ii);
            model.a = model_inc(model.a, aa);
            model.c = model_inc(model.c, cc);
        end
        sb_q.push_back(model);
        @(posedge clk);
        #1;
        pop_and_compare(tag);
    endtask

    // All inputs pulse high for 1 ns between edges; nothing may be counted.
    task automatic glitch_step(input string tag);
        reset                = 1'b0;
        instruction_complete = 1'b1;
        mem_access           = 1'b1;
        mem_correction       = 1'b1;
        #1;
        instruction_complete = 1'b0;
        mem_access           = 1'b0;
        mem_correction       = 1'b0;
        sb_q.push_back(model);
        @(posedge clk);
        #1;
        pop_and_compare(tag);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        model    = '0;
        all_ones = '1;

        // Reset held with every event input high.
        step("rst0", 1'b1, 1'b1, 1'b1, 1'b1);
        step("rst1", 1'b1, 1'b1, 1'b1, 1'b1);

        // One pulse on each input in turn.
        step("seq_inst", 1'b0, 1'b1, 1'b0, 1'b0);
        step("seq_acc", 1'b0, 1'b0, 1'b1, 1'b0);
        step("seq_cor", 1'b0, 1'b0, 1'b0, 1'b1);
        check("seq_end_inst", 32'(instruction_count), 32'd1);
        check("seq_end_cor", 32'(memory_correction_count), 32'd1);

        // Five cycles with all inputs high, then a sub-cycle glitch.
        step("clr5", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) step("all5", 1'b0, 1'b1, 1'b1, 1'b1);
        check("all5_acc", 32'(memory_access_count), 32'd5);
        glitch_step("glitch");
        check("glitch_inst", 32'(instruction_count), 32'd5);

        // Reset overrides simultaneous events, counting resumes next edge.
        step("clr3", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step("to3", 1'b0, 1'b1, 1'b1, 1'b1);
        step("rst_evt", 1'b1, 1'b1, 1'b1, 1'b1);
        check("rst_evt_inst", 32'(instruction_count), 32'd0);
        step("resume", 1'b0, 1'b1, 1'b1, 1'b1);
        check("resume_cor", 32'(memory_correction_count), 32'd1);

        // Correction counts with access low; idle cycles hold.
        step("cor_only", 1'b0, 1'b0, 1'b0, 1'b1);
        step("idle", 1'b0, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 60; k++) begin
            step("rand", 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end

        // Drive every counter to all-ones, then one more event.
        step("clrw", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < (1 << W) - 1; k++) step("fill", 1'b0, 1'b1, 1'b1, 1'b1);
        check("full_inst", 32'(instruction_count), 32'(all_ones));
        step("edge", 1'b0, 1'b1, 1'b1, 1'b1);
`ifdef INC_REG_SATURATE_EN
        check("sat_inst", 32'(instruction_count), 32'(all_ones));
        check("sat_cor", 32'(memory_correction_count), 32'(all_ones));
`else
        check("wrap_inst", 32'(instruction_count), 32'd0);
        check("wrap_cor", 32'(memory_correction_count), 32'd0);
`endif
        step("post_edge", 1'b0, 1'b1, 1'b0, 1'b1);
        step("post_rst", 1'b1, 1'b1, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
